// File: rtl/duty_gen.sv
// duty_gen: double-buffered PWM generator; config swaps only at period ends.
// Optional burst mode (burst_len/burst_done) is enabled by DUTY_GEN_BURST_EN.
module duty_gen #(
  parameter int WIDTH   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [WIDTH-1:0]   period_in,
  input  logic [WIDTH-1:0]   high_in,
`ifdef DUTY_GEN_BURST_EN
  input  logic [BURST_W-1:0] burst_len,
  output logic               burst_done,
`endif
  output logic               sig,
  output logic               busy,
  output logic               period_done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  if (BURST_W < 1) begin : g_chk
    $error("BURST_W must be at least 1");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] act_p, act_h, act_p_n, act_h_n;
  logic [WIDTH-1:0] pend_p, pend_h;
  logic [WIDTH-1:0] eff_p, eff_h;
  logic             pend_v, pend_v_n;
  logic             err_n;
  logic             last;
  logic             fin;
  logic             hold;

  always_comb begin
    // a load in the same cycle beats anything still pending
    eff_p    = load ? period_in : (pend_v ? pend_p : act_p);
    eff_h    = load ? high_in   : (pend_v ? pend_h : act_h);
    last     = (state != IDLE) && (cnt == act_p - ONE);
    state_n  = state;
    cnt_n    = cnt;
    act_p_n  = act_p;
    act_h_n  = act_h;
    pend_v_n = pend_v | load;
    err_n    = cfg_err & ~load;
    case (state)
      IDLE: begin
        if (pend_v && !load) begin
          act_p_n  = pend_p;
          act_h_n  = pend_h;
          pend_v_n = 1'b0;
        end
        if (enable && !hold) begin
          if (eff_p == '0) begin
            if (!load) err_n = 1'b1;
          end else begin
            state_n  = (eff_h != '0) ? HIGH : LOW;
            cnt_n    = '0;
            act_p_n  = eff_p;
            act_h_n  = eff_h;
            pend_v_n = 1'b0;
          end
        end
      end
      default: begin
        if (last) begin
          cnt_n    = '0;
          act_p_n  = eff_p;
          act_h_n  = eff_h;
          pend_v_n = 1'b0;
          if (!enable || fin || eff_p == '0)
            state_n = IDLE;
          else
            state_n = (eff_h != '0) ? HIGH : LOW;
        end else begin
          cnt_n = cnt + ONE;
          if (state == HIGH && cnt == act_h - ONE && act_h < act_p)
            state_n = LOW;
        end
      end
    endcase
  end

  // outputs are taken from the current state, so they trail it by a cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      act_p       <= '0;
      act_h       <= '0;
      pend_p      <= '0;
      pend_h      <= '0;
      pend_v      <= 1'b0;
      cfg_err     <= 1'b0;
      sig         <= 1'b0;
      busy        <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      act_p       <= act_p_n;
      act_h       <= act_h_n;
      pend_v      <= pend_v_n;
      cfg_err     <= err_n;
      sig         <= (state == HIGH);
      busy        <= (state != IDLE);
      period_done <= last;
      if (load) begin
        pend_p <= period_in;
        pend_h <= high_in;
      end
    end
  end

`ifdef DUTY_GEN_BURST_EN
  localparam logic [BURST_W-1:0] BONE = BURST_W'(1);

  logic [BURST_W-1:0] bcnt;
  logic [BURST_W-1:0] blen;

  assign fin = (blen != '0) && (bcnt == blen - BONE);

  // hold blocks a restart until enable has been seen low
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt       <= '0;
      blen       <= '0;
      hold       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= last && fin;
      if (state == IDLE && state_n != IDLE) begin
        bcnt <= '0;
        blen <= burst_len;
      end else if (last) begin
        bcnt <= bcnt + BONE;
      end
      if (last && fin)
        hold <= 1'b1;
      else if (!enable)
        hold <= 1'b0;
    end
  end
`else
  assign fin  = 1'b0;
  assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_duty_gen.sv
// tb_duty_gen: directed stimulus with a queued per-cycle scoreboard.
// Burst checks run when DUTY_GEN_BURST_EN is defined.
module tb_duty_gen;

  localparam int WIDTH   = 32;
  localparam int BURST_W = 16;

  typedef struct packed {
    logic s;
    logic b;
    logic pd;
    logic e;
    logic bd;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               load;
  logic [WIDTH-1:0]   period_in;
  logic [WIDTH-1:0]   high_in;
  logic [BURST_W-1:0] burst_len;
  logic               burst_done;
  logic               sig;
  logic               busy;
  logic               period_done;
  logic               cfg_err;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   done   = 0;

  always #5 clk = ~clk;

  duty_gen #(.WIDTH(WIDTH), .BURST_W(BURST_W)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load(load),
    .period_in(period_in),
    .high_in(high_in),
`ifdef DUTY_GEN_BURST_EN
    .burst_len(burst_len),
    .burst_done(burst_done),
`endif
    .sig(sig),
    .busy(busy),
    .period_done(period_done),
    .cfg_err(cfg_err)
  );

`ifndef DUTY_GEN_BURST_EN
  assign burst_done = 1'b0;
`endif

  task automatic exp_one(input logic s, input logic b, input logic pd,
                         input logic e, input logic bd);
    exp_t x;
    x.s = s; x.b = b; x.pd = pd; x.e = e; x.bd = bd;
    q.push_back(x);
  endtask

  task automatic exp_idle(input int n, input logic e);
    for (int i = 0; i < n; i++) exp_one(1'b0, 1'b0, 1'b0, e, 1'b0);
  endtask

  // one full period as seen on the outputs: cnt 0..p-1
  task automatic exp_per(input int p, input int h, input logic bd_last);
    for (int j = 0; j < p; j++)
      exp_one(j < h, 1'b1, j == p - 1, 1'b0, bd_last && (j == p - 1));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: one scoreboard entry per clock edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_chk++;
        if ({sig, busy, period_done, cfg_err} != {x.s, x.b, x.pd, x.e}) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d got s/b/pd/e=%b%b%b%b want %b%b%b%b",
                   cyc, sig, busy, period_done, cfg_err,
                   x.s, x.b, x.pd, x.e);
        end
`ifdef DUTY_GEN_BURST_EN
        n_chk++;
        if (burst_done != x.bd) begin
          n_fail++;
          $display("FAIL burst_done cyc=%0d got %b want %b",
                   cyc, burst_done, x.bd);
        end
`endif
      end else if (!done) begin
        n_chk++;
        n_fail++;
        $display("FAIL underflow cyc=%0d no expected entry", cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0;
    period_in = '0; high_in = '0; burst_len = '0;
    exp_idle(2, 1'b0); cycles(2);
    reset = 1'b0;

    // 10/3 running, first high one edge after start
    enable = 1'b1; load = 1'b1; period_in = 10; high_in = 3;
    exp_idle(1, 1'b0); cycles(1); load = 1'b0;
    repeat (3) exp_per(10, 3, 1'b0);
    cycles(30);

    // high=0 then high=12 (above period)
    load = 1'b1; high_in = 0;
    exp_per(10, 3, 1'b0); cycles(1); load = 1'b0; cycles(9);
    exp_per(10, 0, 1'b0); load = 1'b1; high_in = 12;
    cycles(1); load = 1'b0; cycles(9);
    repeat (2) exp_per(10, 12, 1'b0);
    cycles(20);

    // back to 10/3, then mid-period load of 20/15
    exp_per(10, 12, 1'b0); high_in = 3; load = 1'b1;
    cycles(1); load = 1'b0; cycles(9);
    exp_per(10, 3, 1'b0); cycles(5);
    period_in = 20; high_in = 15; load = 1'b1;
    cycles(1); load = 1'b0; cycles(4);
    exp_per(20, 15, 1'b0); period_in = 10; high_in = 3; load = 1'b1;
    cycles(1); load = 1'b0; cycles(19);

    // enable dropped and restored inside one period: no gap
    exp_per(10, 3, 1'b0); cycles(3); enable = 1'b0; cycles(3);
    enable = 1'b1; cycles(4);

    // enable dropped at cnt=5: period completes, then idle
    exp_per(10, 3, 1'b0); cycles(5); enable = 1'b0; cycles(5);
    exp_idle(3, 1'b0); cycles(3);

    // period=0 start raises cfg_err; load clears it and starts 8/4
    load = 1'b1; period_in = 0; high_in = 0;
    exp_idle(1, 1'b0); cycles(1); load = 1'b0;
    enable = 1'b1;
    exp_idle(3, 1'b1); cycles(3);
    load = 1'b1; period_in = 8; high_in = 4;
    exp_idle(1, 1'b0); cycles(1); load = 1'b0;
    repeat (2) exp_per(8, 4, 1'b0);
    cycles(16);

    // reset while high
    exp_one(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); cycles(1);
    reset = 1'b1;
    exp_idle(1, 1'b0); cycles(1);
    reset = 1'b0; enable = 1'b0;
    exp_idle(2, 1'b0); cycles(2);
    enable = 1'b1;
    exp_idle(1, 1'b1); cycles(1);

    // period=1: constant high, period_done every cycle
    load = 1'b1; period_in = 1; high_in = 1;
    exp_idle(1, 1'b0); cycles(1); load = 1'b0;
    repeat (4) exp_per(1, 1, 1'b0);
    cycles(3); enable = 1'b0; cycles(1);
    exp_idle(2, 1'b0); cycles(2);

`ifdef DUTY_GEN_BURST_EN
    // burst of 4 periods, then idle with enable still high
    burst_len = 4; enable = 1'b1; load = 1'b1; period_in = 4; high_in = 2;
    exp_idle(1, 1'b0); cycles(1); load = 1'b0;
    repeat (3) exp_per(4, 2, 1'b0);
    exp_per(4, 2, 1'b1);
    exp_idle(3, 1'b0);
    cycles(19);
    enable = 1'b0;
    exp_idle(2, 1'b0); cycles(2);
`endif

    done = 1'b1;
    cycles(2);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover got %0d entries want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
